// File: rtl/downscale_sequencer.sv
// Address/control sequencer for a bilinear downscaler: walks the output grid,
// fetches the four source neighbors per output pixel and hands them to the datapath.
module downscale_sequencer #(
  parameter int WB   = 10,
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 start,
  input  logic                 step_mode,
  input  logic                 step_pulse,
  input  logic [WB-1:0]        in_w,
  input  logic [WB-1:0]        in_h,
  input  logic [WB-1:0]        out_w,
  input  logic [WB-1:0]        out_h,
  input  logic [WB+FRAC-1:0]   scale,
  output logic                 rd_req,
  output logic [2*WB-1:0]      rd_addr,
  input  logic                 rd_ack,
  input  logic [7:0]           rd_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [7:0]           p00,
  output logic [7:0]           p01,
  output logic [7:0]           p10,
  output logic [7:0]           p11,
  output logic [FRAC-1:0]      fx,
  output logic [FRAC-1:0]      fy,
  output logic [WB-1:0]        ox,
  output logic [WB-1:0]        oy,
  output logic                 busy,
  output logic                 done
);

  localparam int AW = WB + FRAC + 1;

  typedef enum logic [2:0] {IDLE, STEP_WAIT, FETCH, OUTPUT, DONE} state_t;

  state_t              state;
  logic [WB-1:0]       in_w_q, in_h_q, out_w_q, out_h_q;
  logic [WB+FRAC-1:0]  scale_q;
  logic [AW-1:0]       acc_x, acc_y;
  logic [1:0]          k;

  logic                last_x, last_y;
  logic [AW-1:0]       acc_x_hs, acc_y_hs;

  // Accumulators saturate instead of wrapping; the coordinate clamp absorbs the excess.
  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [WB+FRAC-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + (AW+1)'(b);
    return s[AW] ? '1 : s[AW-1:0];
  endfunction

  // Neighbor k: bit0 selects x1 over sx, bit1 selects y1 over sy.
  function automatic logic [2*WB-1:0] nbr_addr(
    input logic [AW-1:0] ax,
    input logic [AW-1:0] ay,
    input logic [1:0]    kk,
    input logic [WB-1:0] w,
    input logic [WB-1:0] h
  );
    logic [WB:0] xmax, ymax, sx, sy;
    xmax = {1'b0, w} - (WB+1)'(1);
    ymax = {1'b0, h} - (WB+1)'(1);
    sx = ax[AW-1:FRAC];
    sy = ay[AW-1:FRAC];
    if (sx > xmax) sx = xmax;
    if (sy > ymax) sy = ymax;
    if (kk[0] && (sx < xmax)) sx = sx + (WB+1)'(1);
    if (kk[1] && (sy < ymax)) sy = sy + (WB+1)'(1);
    return (2*WB)'(sy[WB-1:0]) * (2*WB)'(w) + (2*WB)'(sx[WB-1:0]);
  endfunction

  assign last_x = (ox == out_w_q - WB'(1));
  assign last_y = (oy == out_h_q - WB'(1));

  // Accumulator values after a handshake, needed one cycle early to launch the next k=0 read.
  always_comb begin
    acc_x_hs = '0;
    acc_y_hs = acc_y;
    if (!last_x) begin
      acc_x_hs = sat_add(acc_x, scale_q);
    end else begin
      acc_y_hs = sat_add(acc_y, scale_q);
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state     <= IDLE;
      in_w_q    <= '0;
      in_h_q    <= '0;
      out_w_q   <= '0;
      out_h_q   <= '0;
      scale_q   <= '0;
      acc_x     <= '0;
      acc_y     <= '0;
      k         <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      pix_valid <= 1'b0;
      p00       <= '0;
      p01       <= '0;
      p10       <= '0;
      p11       <= '0;
      fx        <= '0;
      fy        <= '0;
      ox        <= '0;
      oy        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            in_w_q  <= in_w;
            in_h_q  <= in_h;
            out_w_q <= out_w;
            out_h_q <= out_h;
            scale_q <= scale;
            ox      <= '0;
            oy      <= '0;
            acc_x   <= '0;
            acc_y   <= '0;
            k       <= '0;
            rd_addr <= '0;
            if ((out_w == '0) || (out_h == '0)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              busy <= 1'b1;
              if (step_mode) begin
                state <= STEP_WAIT;
              end else begin
                state  <= FETCH;
                rd_req <= 1'b1;
              end
            end
          end
        end
        STEP_WAIT: begin
          if (step_pulse) begin
            state   <= FETCH;
            rd_req  <= 1'b1;
            k       <= '0;
            rd_addr <= nbr_addr(acc_x, acc_y, 2'd0, in_w_q, in_h_q);
          end
        end
        FETCH: begin
          if (rd_req && rd_ack) begin
            case (k)
              2'd0:    p00 <= rd_data;
              2'd1:    p01 <= rd_data;
              2'd2:    p10 <= rd_data;
              default: p11 <= rd_data;
            endcase
            if (k == 2'd3) begin
              k         <= '0;
              rd_req    <= 1'b0;
              pix_valid <= 1'b1;
              fx        <= acc_x[FRAC-1:0];
              fy        <= acc_y[FRAC-1:0];
              state     <= OUTPUT;
            end else begin
              k       <= k + 2'd1;
              rd_addr <= nbr_addr(acc_x, acc_y, k + 2'd1, in_w_q, in_h_q);
            end
          end
        end
        OUTPUT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            acc_x     <= acc_x_hs;
            acc_y     <= acc_y_hs;
            if (!last_x) begin
              ox <= ox + WB'(1);
            end else begin
              ox <= '0;
              oy <= oy + WB'(1);
            end
            if (last_x && last_y) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else if (step_mode) begin
              state <= STEP_WAIT;
            end else begin
              state   <= FETCH;
              rd_req  <= 1'b1;
              k       <= '0;
              rd_addr <= nbr_addr(acc_x_hs, acc_y_hs, 2'd0, in_w_q, in_h_q);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
